// File: rtl/acc_delta_decoder_if.sv
// rtl/acc_delta_decoder_if.sv - running-sum input and delta output handshake bundle
interface acc_delta_decoder_if #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_delta;
    logic [CNT_W-1:0] out_index;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_delta, out_index
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_delta, out_index
    );
endinterface

// File: rtl/acc_delta_decoder.sv
// rtl/acc_delta_decoder.sv - recovers per-step increments from a framed running-sum stream
module acc_delta_decoder #(
    parameter int WIDTH       = 6,
    parameter int NUM_SAMPLES = 16,
    parameter int CNT_W       = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    acc_delta_decoder_if.slave   bus,
    output logic                 err_dec,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] prev;
    logic [CNT_W-1:0] count;
    logic             valid_q;
    logic [WIDTH-1:0] delta_q;
    logic [CNT_W-1:0] index_q;
    logic             in_ready;
    logic             accept;
    logic             consume;
    logic             start_run;
    logic             last_word;

    // Ready depends only on state and the output slot, never on in_valid.
    assign in_ready  = (state == RUN) && (!valid_q || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign consume   = valid_q && bus.out_ready;
    assign start_run = start && ((state == IDLE) || (state == DONE));
    assign last_word = (count == CNT_W'(NUM_SAMPLES - 1));

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_delta = delta_q;
    assign bus.out_index = index_q;
    assign busy          = (state == RUN) || (state == DRAIN);
    assign done          = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (accept && last_word) state_next = DRAIN;
            DRAIN:   if (!valid_q || consume) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev    <= '0;
            count   <= '0;
            err_dec <= 1'b0;
            valid_q <= 1'b0;
            delta_q <= '0;
            index_q <= '0;
        end else begin
            if (start_run) begin
                prev    <= '0;
                count   <= '0;
                err_dec <= 1'b0;
            end
            if (accept) begin
                // Subtraction wraps modulo 2^WIDTH even when the sequence decreases.
                delta_q <= bus.in_data - prev;
                index_q <= count;
                prev    <= bus.in_data;
                count   <= count + CNT_W'(1);
                err_dec <= err_dec | (bus.in_data < prev);
                valid_q <= 1'b1;
            end else if (consume) begin
                valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_acc_delta_decoder.sv
// tb/tb_acc_delta_decoder.sv - directed and randomized checks against a queue-based delta model
module tb_acc_delta_decoder;
    localparam int WIDTH       = 6;
    localparam int NUM_SAMPLES = 16;
    localparam int CNT_W       = 5;
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [CNT_W-1:0] i;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic err_dec, busy, done;

    acc_delta_decoder_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) iface ();

    acc_delta_decoder #(.WIDTH(WIDTH), .NUM_SAMPLES(NUM_SAMPLES), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bus     (iface.slave),
        .err_dec (err_dec),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    ent_t             q[$];
    int               m_phase = P_IDLE;
    logic [WIDTH-1:0] m_prev = '0;
    int               m_count = 0;
    logic             m_err = 1'b0;
    logic             last_acc = 1'b0;
    logic             rnd_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock: compare outputs before the edge, then advance the model across it.
    task automatic cycle();
        logic exp_ir, acc, con;
        int   ph;
        @(negedge clk);
        exp_ir = (m_phase == P_RUN) && ((q.size() == 0) || iface.out_ready);
        chk("in_ready",  32'(iface.in_ready),  32'(exp_ir));
        chk("out_valid", 32'(iface.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_delta", 32'(iface.out_delta), 32'(q[0].d));
            chk("out_index", 32'(iface.out_index), 32'(q[0].i));
        end
        chk("err_dec", 32'(err_dec), 32'(m_err));
        chk("busy", 32'(busy), 32'((m_phase == P_RUN) || (m_phase == P_DRAIN)));
        chk("done", 32'(done), 32'(m_phase == P_DONE));
        acc = iface.in_valid && exp_ir;
        con = (q.size() != 0) && iface.out_ready;
        ph  = m_phase;
        if (con) void'(q.pop_front());
        if (acc) begin
            q.push_back('{d: iface.in_data - m_prev, i: CNT_W'(m_count)});
            if (iface.in_data < m_prev) m_err = 1'b1;
            m_prev = iface.in_data;
            m_count++;
            if (m_count == NUM_SAMPLES) m_phase = P_DRAIN;
        end
        if (ph == P_DRAIN && q.size() == 0) m_phase = P_DONE;
        if ((ph == P_IDLE || ph == P_DONE) && start) begin
            m_phase = P_RUN;
            m_prev  = '0;
            m_count = 0;
            m_err   = 1'b0;
        end
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        iface.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        m_phase = P_IDLE;
        m_prev  = '0;
        m_count = 0;
        m_err   = 1'b0;
        chk("rst_out_valid", 32'(iface.out_valid), 32'(0));
        chk("rst_in_ready",  32'(iface.in_ready),  32'(0));
        chk("rst_out_delta", 32'(iface.out_delta), 32'(0));
        chk("rst_out_index", 32'(iface.out_index), 32'(0));
        chk("rst_err_dec",   32'(err_dec),         32'(0));
        chk("rst_busy",      32'(busy),            32'(0));
        chk("rst_done",      32'(done),            32'(0));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic feed(input logic [WIDTH-1:0] w);
        iface.in_valid = 1'b1;
        iface.in_data  = w;
        for (int t = 0; t < 64; t++) begin
            if (rnd_ready) iface.out_ready = 1'($urandom_range(0, 1));
            cycle();
            if (last_acc) break;
        end
        chk("feed_accept", 32'(last_acc), 32'(1));
        iface.in_valid = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] next_word();
        return m_prev + WIDTH'($urandom_range(0, 4));
    endfunction

    task automatic finish_run();
        for (int g = 0; g < 40 && m_phase == P_RUN; g++) begin
            repeat ($urandom_range(0, 1)) cycle();
            feed(next_word());
        end
        iface.out_ready = 1'b1;
        for (int g = 0; g < 8 && m_phase != P_DONE; g++) cycle();
        cycle();
        chk("done_after_run", 32'(done), 32'(1));
    endtask

    initial begin
        iface.in_valid  = 1'b0;
        iface.in_data   = '0;
        iface.out_ready = 1'b1;
        @(posedge clk);
        do_reset();

        // Basic sequence with downstream always ready.
        pulse_start();
        feed(6'd0); feed(6'd1); feed(6'd1); feed(6'd3); feed(6'd6); feed(6'd10);
        finish_run();
        iface.in_valid = 1'b1;
        iface.in_data  = 6'd5;
        repeat (3) cycle();
        iface.in_valid = 1'b0;

        // Downstream stall with pending input, then release without a gap.
        pulse_start();
        feed(6'd4); feed(6'd9);
        iface.out_ready = 1'b0;
        iface.in_valid  = 1'b1;
        iface.in_data   = 6'd12;
        repeat (3) cycle();
        iface.out_ready = 1'b1;
        cycle();
        chk("no_gap_accept", 32'(last_acc), 32'(1));
        iface.in_valid = 1'b0;
        finish_run();

        // Decrease with wrap: 62 then 1 yields delta 3 and a sticky error.
        pulse_start();
        feed(6'd20); feed(6'd62); feed(6'd1);
        finish_run();
        chk("err_sticky_end", 32'(err_dec), 32'(1));
        pulse_start();
        chk("err_cleared", 32'(err_dec), 32'(0));
        finish_run();

        // Randomized backpressure over several full runs.
        rnd_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            pulse_start();
            for (int k = 0; k < 5; k++) feed(WIDTH'($urandom));
            finish_run();
        end
        rnd_ready = 1'b0;

        // Reset in mid-run, then a fresh run.
        pulse_start();
        for (int k = 0; k < 5; k++) feed(next_word());
        do_reset();
        cycle();
        pulse_start();
        feed(6'd7);
        cycle();
        finish_run();

        // Start pulses during RUN must be ignored.
        pulse_start();
        feed(6'd2); feed(6'd5);
        start = 1'b1;
        feed(6'd8); feed(6'd9);
        start = 1'b0;
        finish_run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
